// File: rtl/tensor_result_drain.sv
// tensor_result_drain
//   Captures completed 4x4 FP32 result tiles (plus tag) from the tensor
//   dot-product unit into a small FIFO and replays each tile one row per beat
//   on a valid/ready writeback port. Back-pressure reaches the result pipeline
//   through stall_out, which is a pure function of registered occupancy.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset (control state only)
//   in_valid     : upstream tile present; held stable while stall_out is high
//   in_tag       : tag travelling with the tile
//   in_tile      : tile, row r at [r*COLS*32 +: COLS*32], column c at [c*32 +: 32]
//   stall_out    : buffer full, upstream must freeze
//   out_valid    : row beat valid
//   out_ready    : consumer accepts the beat
//   out_tag      : tag of the tile being drained
//   out_row      : row index of the current beat
//   out_data     : row payload
//   out_last     : final row of the tile
//   busy         : buffer holds at least one tile
module tensor_result_drain #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [TAG_W-1:0]                    in_tag,
  input  logic [ROWS*COLS*32-1:0]             in_tile,
  output logic                                stall_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [TAG_W-1:0]                    out_tag,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [COLS*32-1:0]                  out_data,
  output logic                                out_last,
  output logic                                busy
);

  localparam int ROW_BITS = COLS * 32;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Tile storage: data only, never reset.
  logic [TAG_W-1:0]                   tag_mem_q  [DEPTH];
  logic [ROWS-1:0][ROW_BITS-1:0]      tile_mem_q [DEPTH];

  // Control state.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [ROW_W-1:0] row_q,    row_d;

  logic push;
  logic beat;
  logic pop;

  // Outputs decode registered state only; no in_valid/out_ready feed-through.
  assign stall_out = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign busy      = out_valid;
  assign out_tag   = tag_mem_q[rd_ptr_q];
  assign out_data  = tile_mem_q[rd_ptr_q][row_q];
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == LAST_ROW);

  always_comb begin
    push     = in_valid && !stall_out;
    beat     = out_valid && out_ready;
    pop      = beat && (row_q == LAST_ROW);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    row_d    = row_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (beat) begin
      row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---- capture stage: write tile at wr_ptr ----
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q]  <= in_tag;
      tile_mem_q[wr_ptr_q] <= in_tile;
    end
  end

  // ---- control state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      row_q    <= row_d;
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == FULL_CNT)));

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) &&
                                   $stable(out_tag) && $stable(out_row)));

  a_row_bound: assert property (@(posedge clk) disable iff (reset)
    row_q <= LAST_ROW);
`endif

endmodule
